// File: rtl/branch_stats_reporter.sv
// Branch predictor statistics reporter.
// Snapshots three counters and sends a 14-byte UART 8N1 frame.
module branch_stats_reporter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] total_branches,
  input  logic [31:0] correct_sbp,
  input  logic [31:0] correct_dbp,
  input  logic        report_req,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BYTE = 4'd13;
  localparam logic [7:0]  HEADER    = 8'hA5;

  state_t      state;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [3:0]  byte_idx;
  logic [31:0] snap_tot;
  logic [31:0] snap_sbp;
  logic [31:0] snap_dbp;

  logic [7:0]  csum;
  logic [7:0]  cur_byte;
  logic [2:0]  nxt_bit;
  logic        bit_end;

  assign bit_end = (timer == LAST_TICK);
  assign nxt_bit = bit_idx + 3'd1;

  always_comb begin
    csum = snap_tot[31:24] + snap_tot[23:16]
         + snap_tot[15:8]  + snap_tot[7:0]
         + snap_sbp[31:24] + snap_sbp[23:16]
         + snap_sbp[15:8]  + snap_sbp[7:0]
         + snap_dbp[31:24] + snap_dbp[23:16]
         + snap_dbp[15:8]  + snap_dbp[7:0];
  end

  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx)
      4'd0:    cur_byte = HEADER;
      4'd1:    cur_byte = snap_tot[31:24];
      4'd2:    cur_byte = snap_tot[23:16];
      4'd3:    cur_byte = snap_tot[15:8];
      4'd4:    cur_byte = snap_tot[7:0];
      4'd5:    cur_byte = snap_sbp[31:24];
      4'd6:    cur_byte = snap_sbp[23:16];
      4'd7:    cur_byte = snap_sbp[15:8];
      4'd8:    cur_byte = snap_sbp[7:0];
      4'd9:    cur_byte = snap_dbp[31:24];
      4'd10:   cur_byte = snap_dbp[23:16];
      4'd11:   cur_byte = snap_dbp[15:8];
      4'd12:   cur_byte = snap_dbp[7:0];
      4'd13:   cur_byte = csum;
      default: cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      snap_tot <= '0;
      snap_sbp <= '0;
      snap_dbp <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (report_req) begin
            snap_tot <= total_branches;
            snap_sbp <= correct_sbp;
            snap_dbp <= correct_dbp;
            state    <= START_BIT;
            uart_tx  <= 1'b0;
            busy     <= 1'b1;
            timer    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end
        START_BIT: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= DATA_BITS;
            uart_tx <= cur_byte[0];
          end else begin
            timer <= timer + 16'd1;
          end
        end
        DATA_BITS: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP_BIT;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= nxt_bit;
              uart_tx <= cur_byte[nxt_bit];
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        STOP_BIT: begin
          if (bit_end) begin
            timer <= '0;
            // Last stop bit ends the frame; otherwise start next byte at once.
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              uart_tx  <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              state    <= START_BIT;
              uart_tx  <= 1'b0;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_stats_reporter.sv
// Bench for branch_stats_reporter: directed and random frames
// checked cycle by cycle against a frame model.
module tb_branch_stats_reporter;

  localparam int C = 4;
  localparam int FRAME = 14 * 10 * C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] total_branches;
  logic [31:0] correct_sbp;
  logic [31:0] correct_dbp;
  logic        report_req;
  logic        uart_tx;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] exp_b [14];

  always #5 clk = ~clk;

  branch_stats_reporter #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst(rst),
    .total_branches(total_branches),
    .correct_sbp(correct_sbp),
    .correct_dbp(correct_dbp),
    .report_req(report_req),
    .uart_tx(uart_tx),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".tx"}, 32'(uart_tx), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
  endtask

  // Frame model: header, three counters MSB first, byte-sum checksum.
  task automatic build_exp(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
    int sum;
    logic [31:0] w [3];
    w[0] = a; w[1] = b; w[2] = c;
    exp_b[0] = 8'hA5;
    sum = 0;
    for (int k = 0; k < 12; k++) begin
      exp_b[1 + k] = 8'((w[k / 4] >> (24 - 8 * (k % 4))) & 32'hFF);
      sum += int'(exp_b[1 + k]);
    end
    exp_b[13] = 8'(sum % 256);
  endtask

  function automatic logic exp_bit(input int i);
    int b;
    int p;
    b = i / C;
    p = b % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return exp_b[b / 10][p - 1];
  endfunction

  // mode 0: drop req; 1: re-pulse req and change counters;
  // 2: drop req late; 3: reset during byte 6; 4: hold req.
  task automatic frame(input int mode);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk($sformatf("tx[%0d]", i), 32'(uart_tx), 32'(exp_bit(i)));
      chk($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
      chk($sformatf("done[%0d]", i), 32'(done), 32'd0);
      if (mode != 4 && mode != 2 && i == 0) report_req = 1'b0;
      if (mode == 2 && i == 5) report_req = 1'b0;
      if (mode == 1) begin
        if (i == 10 || i == 300) report_req = 1'b1;
        if (i == 11 || i == 301) report_req = 1'b0;
        if (i == 20) begin
          total_branches = $urandom;
          correct_sbp = $urandom;
          correct_dbp = $urandom;
        end
      end
      if (mode == 3 && i == 245) begin
        rst = 1'b1;
        return;
      end
    end
  endtask

  task automatic done_chk(input string tag);
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".tx"}, 32'(uart_tx), 32'd1);
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    @(negedge clk);
    total_branches = a;
    correct_sbp = b;
    correct_dbp = c;
    report_req = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    report_req = 1'b0;
    total_branches = '0;
    correct_sbp = '0;
    correct_dbp = '0;
    repeat (3) @(negedge clk);
    idle_chk("reset");
    rst = 1'b0;
    @(negedge clk);
    idle_chk("post_reset");

    exp_b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
              8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h0E, 8'h2A};
    start(32'h10, 32'h0C, 32'h0E);
    frame(0);
    done_chk("small");
    repeat (5) begin
      @(negedge clk);
      idle_chk("small_after");
    end

    exp_b = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF4};
    start(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    frame(0);
    done_chk("ones");

    for (int r = 0; r < 3; r++) begin
      logic [31:0] a, b, c;
      a = $urandom; b = $urandom; c = $urandom;
      build_exp(a, b, c);
      start(a, b, c);
      frame(0);
      done_chk("rand");
    end

    begin
      logic [31:0] a, b, c;
      a = $urandom; b = $urandom; c = $urandom;
      build_exp(a, b, c);
      start(a, b, c);
      frame(1);
      done_chk("repulse");
      repeat (10) begin
        @(negedge clk);
        idle_chk("repulse_after");
      end
    end

    begin
      logic [31:0] a, b, c;
      a = $urandom; b = $urandom; c = $urandom;
      build_exp(a, b, c);
      start(a, b, c);
      frame(4);
      done_chk("b2b_first");
      frame(2);
      done_chk("b2b_second");
      @(negedge clk);
      idle_chk("b2b_after");
    end

    begin
      logic [31:0] a, b, c;
      a = $urandom; b = $urandom; c = $urandom;
      build_exp(a, b, c);
      start(a, b, c);
      frame(3);
      @(negedge clk);
      idle_chk("abort");
      rst = 1'b0;
      repeat (20) begin
        @(negedge clk);
        idle_chk("abort_after");
      end
      a = $urandom; b = $urandom; c = $urandom;
      build_exp(a, b, c);
      start(a, b, c);
      frame(0);
      done_chk("after_abort");
    end

    @(negedge clk);
    rst = 1'b1;
    report_req = 1'b1;
    @(negedge clk);
    idle_chk("rst_prio");
    rst = 1'b0;
    report_req = 1'b0;
    repeat (20) begin
      @(negedge clk);
      idle_chk("rst_prio_after");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_stats_reporter.md
BRANCH_STATS_REPORTER -- requirements
Module: branch_stats_reporter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all logic updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port total_branches  input  32  branch-instruction count from the branch predictor.
REQ-005 SHALL have port correct_sbp  input  32  static-predictor correct-prediction count.
REQ-006 SHALL have port correct_dbp  input  32  dynamic-predictor correct-prediction count.
REQ-007 SHALL have port report_req  input  1  request to snapshot and transmit one report frame.
REQ-008 SHALL have port uart_tx  output  1  UART 8N1 serial line; idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 SHALL implement a state machine with states IDLE, START_BIT, DATA_BITS and STOP_BIT.
REQ-012 SHALL, in IDLE with report_req high at a rising edge, copy all three counters into internal snapshot registers on that edge and enter START_BIT.
REQ-013 SHALL ignore report_req whenever the state is not IDLE, with no queuing and no snapshot update.
REQ-014 SHALL transmit a 14-byte frame: byte 0 = 0xA5 header; bytes 1-4 = total_branches; bytes 5-8 = correct_sbp; bytes 9-12 = correct_dbp; byte 13 = checksum.
REQ-015 SHALL send each 32-bit counter most-significant byte first.
REQ-016 SHALL compute the checksum as the sum of bytes 1-12, modulo 256, taken from snapshot values; the header is excluded.
REQ-017 SHALL send each byte as: start bit 0, then 8 data bits LSB first, then stop bit 1; every bit lasts exactly CLKS_PER_BIT cycles.
REQ-018 SHALL place no idle gap between bytes: the stop bit of byte k is followed immediately by the start bit of byte k+1.
REQ-019 SHALL drive uart_tx low starting in the cycle immediately after the accepting edge (latency 1 cycle).
REQ-020 SHALL make the total frame length exactly 140*CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle inclusive.
REQ-021 SHALL hold busy high in every non-IDLE state and low in IDLE.
REQ-022 SHALL assert done for exactly the first IDLE cycle after the final stop bit of byte 13.
REQ-023 SHALL accept a report_req that is high during the done cycle, making back-to-back frames possible.
REQ-024 SHALL use a bit-timer counter that counts 0..CLKS_PER_BIT-1 and wraps; the bit index wraps 7->0 and the byte index counts 0..13.
REQ-025 SHALL keep uart_tx free of glitches by driving it from a register.
REQ-026 SHALL not be affected in the frame in flight by any change on the counter inputs after the accepting edge.

Reset
REQ-027 SHALL, when rst is high at an edge, force the state to IDLE, uart_tx=1, busy=0, done=0, and clear the timer, bit index, byte index and snapshot registers to 0.
REQ-028 SHALL give rst priority over report_req in the same cycle; the request is discarded.
REQ-029 SHALL abort any frame in progress when reset is applied; uart_tx returns high on the cycle after the reset edge, and no done pulse is produced.

Verification (CLKS_PER_BIT=4)
REQ-030 SHALL verify: counters 0x00000010 / 0x0000000C / 0x0000000E with one report_req pulse -> decoded bytes A5 00 00 00 10 00 00 00 0C 00 00 00 0E 2A; busy high for 560 cycles; done pulses once.
REQ-031 SHALL verify: all counters 0xFFFFFFFF -> bytes A5, then twelve FF, then checksum F4.
REQ-032 SHALL verify: report_req re-pulsed at cycles 10 and 300 of a frame, and counters changed mid-frame -> single frame carrying the original snapshot values.
REQ-033 SHALL verify: report_req held high continuously -> frames back-to-back, the second starting the cycle after done, with uart_tx low one cycle after the done cycle.
REQ-034 SHALL verify: rst asserted during byte 6 -> uart_tx=1 and busy=0 the next cycle, no done pulse; a subsequent request produces a complete, correct frame.
REQ-035 SHALL verify: rst and report_req high in the same cycle -> remains IDLE, uart_tx stays 1, no frame is sent.
